// File: rtl/scan_select_seq_if.sv
// Handshake/select bundle between the scan sequencer and its controller.
// The master drives the run controls; the slave (the sequencer) drives the decoder selects and status.
interface scan_select_seq_if;
    logic       en;
    logic       dir;
    logic       oneshot;
    logic       load;
    logic [1:0] load_val;
    logic       a;
    logic       b;
    logic       step;
    logic       wrap;
    logic       busy;
    logic       done;

    modport master (
        output en, dir, oneshot, load, load_val,
        input  a, b, step, wrap, busy, done
    );

    modport slave (
        input  en, dir, oneshot, load, load_val,
        output a, b, step, wrap, busy, done
    );
endinterface

// File: rtl/scan_select_seq.sv
// Sequential A/B select generator for a 2-to-4 decoder: programmable dwell, up/down, sweep or continuous.
// Optional macro SCAN_SEL_GRAY_EN presents the index Gray-coded on A/B.
module scan_select_seq #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    scan_select_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [2:0]       sweep_q, sweep_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             adv;

    // Advance edge: dwell expired while running; LOAD and EN low take precedence.
    assign adv = (state_q == S_RUN) && bus.en && !bus.load && (dwell_q == DWELL_LAST);

    // State register and all registered datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            sel_q   <= 2'd0;
            dwell_q <= '0;
            sweep_q <= 3'd0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            sweep_q <= sweep_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = bus.en ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.en) state_d = S_RUN;
                S_RUN: begin
                    if (!bus.en)
                        state_d = S_IDLE;
                    // sweep_q counts completed advances; this advance makes it >= 4
                    else if (adv && bus.oneshot && (sweep_q >= 3'd3))
                        state_d = S_DONE;
                end
                S_DONE: if (!bus.en) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        sweep_d = sweep_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.load) begin
            idx_d   = bus.load_val;
            dwell_d = '0;
            sweep_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dwell_d = '0;
                    if (bus.en) sweep_d = 3'd0;
                end
                S_RUN: begin
                    if (!bus.en) begin
                        dwell_d = '0;
                    end else if (adv) begin
                        dwell_d = '0;
                        idx_d   = bus.dir ? (idx_q - 2'd1) : (idx_q + 2'd1);
                        step_d  = 1'b1;
                        wrap_d  = bus.dir ? (idx_q == 2'd0) : (idx_q == 2'd3);
                        // saturate: only ">= 4" matters once the sweep is complete
                        if (sweep_q != 3'd4) sweep_d = sweep_q + 3'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef SCAN_SEL_GRAY_EN
        sel_d = {idx_d[1], idx_d[1] ^ idx_d[0]};
`else
        sel_d = idx_d;
`endif
    end

    assign bus.a    = sel_q[1];
    assign bus.b    = sel_q[0];
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_scan_select_seq.sv
// Self-checking bench for scan_select_seq: directed test-plan sequences plus randomized controls
// compared each cycle against a position/hold-time reference model.
module tb_scan_select_seq;
    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst_n;
    scan_select_seq_if bus ();

    scan_select_seq #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode 0=idle 1=run 2=done, position, cycles held, advances since start
    int m_mode, m_pos, m_held, m_adv;
    bit m_step, m_wrap;
    logic [1:0] prev_ab;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input int p);
        logic [1:0] v;
        v = 2'(p);
`ifdef SCAN_SEL_GRAY_EN
        return {v[1], v[1] ^ v[0]};
`else
        return v;
`endif
    endfunction

    task automatic model_edge();
        int old;
        m_step = 0;
        m_wrap = 0;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_held = 0; m_adv = 0;
        end else if (bus.load) begin
            m_pos = int'(bus.load_val); m_held = 0; m_adv = 0;
            m_mode = bus.en ? 1 : 0;
        end else if (m_mode == 0) begin
            if (bus.en) begin m_mode = 1; m_held = 0; m_adv = 0; end
        end else if (m_mode == 1) begin
            if (!bus.en) begin
                m_mode = 0; m_held = 0;
            end else begin
                m_held++;
                if (m_held == DWELL) begin
                    old    = m_pos;
                    m_held = 0;
                    m_pos  = bus.dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
                    m_step = 1;
                    m_wrap = bus.dir ? (old == 0) : (old == 3);
                    m_adv++;
                    if (bus.oneshot && m_adv >= 4) m_mode = 2;
                end
            end
        end else if (!bus.en) begin
            m_mode = 0;
        end
    endtask

    // One clock: inputs already set at negedge; model tracks the edge; compare at next negedge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".ab"},   {30'd0, bus.a, bus.b}, {30'd0, enc(m_pos)});
        chk({tag, ".step"}, {31'd0, bus.step}, {31'd0, m_step});
        chk({tag, ".wrap"}, {31'd0, bus.wrap}, {31'd0, m_wrap});
        chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, m_mode == 1});
        chk({tag, ".done"}, {31'd0, bus.done}, {31'd0, m_mode == 2});
`ifdef SCAN_SEL_GRAY_EN
        if (bus.step && !bus.load_val[0] && 1'b1)
            chk({tag, ".gray1"}, {31'd0, $countones({bus.a, bus.b} ^ prev_ab) == 1}, 32'd1);
`endif
        prev_ab = {bus.a, bus.b};
    endtask

    task automatic drive(input bit en, input bit dir, input bit os, input bit ld, input logic [1:0] lv);
        bus.en = en; bus.dir = dir; bus.oneshot = os; bus.load = ld; bus.load_val = lv;
    endtask

    initial begin
        m_mode = 0; m_pos = 0; m_held = 0; m_adv = 0; m_step = 0; m_wrap = 0;
        prev_ab = 2'b00;
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 2'd0);
        @(negedge clk);

        // Reset held with EN=1
        cycle("rst0");
        cycle("rst1");
        chk("rst.ab",   {30'd0, bus.a, bus.b}, 32'd0);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        cycle("rel");
        chk("rel.busy", {31'd0, bus.busy}, 32'd1);

        // Continuous up count
        for (int i = 0; i < 20; i++) cycle("up");

        // Down from index 0: first advance wraps to 3
        drive(1, 1, 0, 1, 2'd0);
        cycle("ldn");
        drive(1, 1, 0, 0, 2'd0);
        for (int i = 0; i < DWELL; i++) cycle("dn");
        chk("dn.first", {30'd0, bus.a, bus.b}, {30'd0, enc(3)});
        chk("dn.wrap",  {31'd0, bus.wrap}, 32'd1);
        for (int i = 0; i < 3 * DWELL; i++) cycle("dn");

        // Oneshot sweep from position 2
        drive(0, 0, 1, 1, 2'd2);
        cycle("os.ld");
        drive(1, 0, 1, 0, 2'd0);
        for (int i = 0; i < 4 * DWELL + 1; i++) cycle("os");
        chk("os.done", {31'd0, bus.done}, 32'd1);
        chk("os.busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 6; i++) cycle("os.hold");
        chk("os.pos", {30'd0, bus.a, bus.b}, {30'd0, enc(2)});
        drive(0, 0, 1, 0, 2'd0);
        cycle("os.off");
        chk("os.idle", {31'd0, bus.done}, 32'd0);

        // LOAD coincident with a scheduled advance from index 1
        drive(1, 0, 0, 1, 2'd1);
        cycle("la.ld");
        drive(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < DWELL - 1; i++) cycle("la");
        drive(1, 0, 0, 1, 2'd3);
        cycle("la.hit");
        chk("la.nostep", {31'd0, bus.step}, 32'd0);
        chk("la.pos", {30'd0, bus.a, bus.b}, {30'd0, enc(3)});
        drive(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < DWELL; i++) cycle("la.after");
        chk("la.step", {31'd0, bus.step}, 32'd1);

        // Randomized controls
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0 ? ~bus.dir : bus.dir,
                  $urandom_range(0, 15) == 0 ? ~bus.oneshot : bus.oneshot,
                  $urandom_range(0, 39) == 0, 2'($urandom));
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
